// File: rtl/ps2_scancode_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg : shared constants, FSM states and event record for the decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ps2_pkg;

   localparam logic [7:0] C_PFX_E0 = 8'hE0;
   localparam logic [7:0] C_PFX_F0 = 8'hF0;
   localparam logic [7:0] C_PFX_E1 = 8'hE1;

   localparam logic [7:0] C_KEY_LSHIFT = 8'h12;
   localparam logic [7:0] C_KEY_RSHIFT = 8'h59;
   localparam logic [7:0] C_KEY_CTRL   = 8'h14;
   localparam logic [7:0] C_KEY_ALT    = 8'h11;
   localparam logic [7:0] C_KEY_CAPS   = 8'h58;

   // Pause is E1 followed by seven more bytes that carry no extra meaning.
   localparam logic [2:0] C_PAUSE_SKIP = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_EXT     = 3'd1,
      S_BRK     = 3'd2,
      S_EXT_BRK = 3'd3,
      S_PAUSE   = 3'd4
   } state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       rel;
      logic [7:0] ascii;
   } event_t;

   function automatic logic is_ignored(input logic [7:0] i_byte);
      case (i_byte)
         8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: return 1'b1;
         default:                                  return 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_scancode_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_ev_if : key-event ready/valid handshake between decoder and consumer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ps2_ev_if;

   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_release;
   logic [7:0] ev_ascii;

   modport master (
      output ev_valid,
      input  ev_ready,
      output ev_code,
      output ev_ext,
      output ev_release,
      output ev_ascii
   );

   modport slave (
      input  ev_valid,
      output ev_ready,
      input  ev_code,
      input  ev_ext,
      input  ev_release,
      input  ev_ascii
   );

endinterface

`default_nettype wire

// File: rtl/ps2_scancode_decoder_ascii_map.sv
// ---------------------------------------------------------------------------
// ps2_ascii_map : combinational Set-2 scan code to ASCII lookup
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_ascii_map
   import ps2_pkg::*;
(
   input  logic [7:0] i_code,
   input  logic       i_ext,
   input  logic       i_shift,
   input  logic       i_caps,
   output logic [7:0] o_ascii
);

   logic [7:0] w_lower;
   logic [7:0] w_norm;
   logic [7:0] w_shft;

   always_comb begin
      w_lower = 8'h00;
      w_norm  = 8'h00;
      w_shft  = 8'h00;
      case (i_code)
         8'h1C: w_lower = 8'h61;
         8'h32: w_lower = 8'h62;
         8'h21: w_lower = 8'h63;
         8'h23: w_lower = 8'h64;
         8'h24: w_lower = 8'h65;
         8'h2B: w_lower = 8'h66;
         8'h34: w_lower = 8'h67;
         8'h33: w_lower = 8'h68;
         8'h43: w_lower = 8'h69;
         8'h3B: w_lower = 8'h6A;
         8'h42: w_lower = 8'h6B;
         8'h4B: w_lower = 8'h6C;
         8'h3A: w_lower = 8'h6D;
         8'h31: w_lower = 8'h6E;
         8'h44: w_lower = 8'h6F;
         8'h4D: w_lower = 8'h70;
         8'h15: w_lower = 8'h71;
         8'h2D: w_lower = 8'h72;
         8'h1B: w_lower = 8'h73;
         8'h2C: w_lower = 8'h74;
         8'h3C: w_lower = 8'h75;
         8'h2A: w_lower = 8'h76;
         8'h1D: w_lower = 8'h77;
         8'h22: w_lower = 8'h78;
         8'h35: w_lower = 8'h79;
         8'h1A: w_lower = 8'h7A;
         8'h45: begin w_norm = 8'h30; w_shft = 8'h29; end
         8'h16: begin w_norm = 8'h31; w_shft = 8'h21; end
         8'h1E: begin w_norm = 8'h32; w_shft = 8'h40; end
         8'h26: begin w_norm = 8'h33; w_shft = 8'h23; end
         8'h25: begin w_norm = 8'h34; w_shft = 8'h24; end
         8'h2E: begin w_norm = 8'h35; w_shft = 8'h25; end
         8'h36: begin w_norm = 8'h36; w_shft = 8'h5E; end
         8'h3D: begin w_norm = 8'h37; w_shft = 8'h26; end
         8'h3E: begin w_norm = 8'h38; w_shft = 8'h2A; end
         8'h46: begin w_norm = 8'h39; w_shft = 8'h28; end
         8'h0E: begin w_norm = 8'h60; w_shft = 8'h7E; end
         8'h4E: begin w_norm = 8'h2D; w_shft = 8'h5F; end
         8'h55: begin w_norm = 8'h3D; w_shft = 8'h2B; end
         8'h54: begin w_norm = 8'h5B; w_shft = 8'h7B; end
         8'h5B: begin w_norm = 8'h5D; w_shft = 8'h7D; end
         8'h5D: begin w_norm = 8'h5C; w_shft = 8'h7C; end
         8'h4C: begin w_norm = 8'h3B; w_shft = 8'h3A; end
         8'h52: begin w_norm = 8'h27; w_shft = 8'h22; end
         8'h41: begin w_norm = 8'h2C; w_shft = 8'h3C; end
         8'h49: begin w_norm = 8'h2E; w_shft = 8'h3E; end
         8'h4A: begin w_norm = 8'h2F; w_shft = 8'h3F; end
         // Control keys ignore shift, so both columns hold the same value.
         8'h29: begin w_norm = 8'h20; w_shft = 8'h20; end
         8'h5A: begin w_norm = 8'h0D; w_shft = 8'h0D; end
         8'h66: begin w_norm = 8'h08; w_shft = 8'h08; end
         8'h76: begin w_norm = 8'h1B; w_shft = 8'h1B; end
         8'h0D: begin w_norm = 8'h09; w_shft = 8'h09; end
         default: begin end
      endcase
   end

   always_comb begin
      o_ascii = 8'h00;
      if (i_ext) begin
         if (i_code == 8'h5A)
            o_ascii = 8'h0D;
         else if (i_code == 8'h4A)
            o_ascii = 8'h2F;
      end else if (w_lower != 8'h00) begin
         o_ascii = (i_shift ^ i_caps) ? (w_lower - 8'h20) : w_lower;
      end else begin
         o_ascii = i_shift ? w_shft : w_norm;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// ps2_scancode_decoder : resolves Set-2 prefix sequences into buffered key events
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 250000
) (
   input  logic       clock_25,
   input  logic       reset,
   input  logic       keyb_ready,
   input  logic [7:0] keyb_data,
   ps2_ev_if.master   ev,
   output logic       mod_shift,
   output logic       mod_ctrl,
   output logic       mod_alt,
   output logic       caps_lock,
   output logic       overflow
);

   localparam int C_AW = $clog2(FIFO_DEPTH);
   localparam int C_TW = $clog2(TIMEOUT_CYC + 1);

   state_t          r_state;
   state_t          w_next;
   logic [2:0]      r_skip;
   logic [2:0]      w_skip_nxt;
   logic [C_TW-1:0] r_tmo;
   logic            w_timeout;

   logic            w_emit;
   logic            w_ext;
   logic            w_rel;
   logic [7:0]      w_code;
   logic [7:0]      w_ascii;

   event_t          r_ev;
   logic            r_ev_vld;

   logic            r_lshift, r_rshift;
   logic            r_lctrl, r_rctrl;
   logic            r_lalt, r_ralt;
   logic            r_caps;
   logic            r_ovf;

   event_t          r_mem [FIFO_DEPTH];
   logic [C_AW:0]   r_wptr, r_rptr;
   logic            w_empty, w_full, w_pop, w_push;
   event_t          w_head;

   assign w_timeout = (r_state != S_IDLE) && (r_tmo == C_TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clock_25) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_skip  <= 3'd0;
      end else begin
         r_state <= w_next;
         r_skip  <= w_skip_nxt;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_skip_nxt = r_skip;
      w_emit     = 1'b0;
      w_ext      = 1'b0;
      w_rel      = 1'b0;
      w_code     = keyb_data;
      if (keyb_ready) begin
         case (r_state)
            S_IDLE: begin
               if (keyb_data == C_PFX_E0) begin
                  w_next = S_EXT;
               end else if (keyb_data == C_PFX_F0) begin
                  w_next = S_BRK;
               end else if (keyb_data == C_PFX_E1) begin
                  w_next     = S_PAUSE;
                  w_skip_nxt = C_PAUSE_SKIP;
               end else if (!is_ignored(keyb_data)) begin
                  w_emit = 1'b1;
               end
            end
            S_EXT: begin
               if (keyb_data == C_PFX_F0) begin
                  w_next = S_EXT_BRK;
               end else if (keyb_data != C_PFX_E0) begin
                  w_emit = 1'b1;
                  w_ext  = 1'b1;
                  w_next = S_IDLE;
               end
            end
            S_BRK: begin
               w_emit = 1'b1;
               w_rel  = 1'b1;
               w_next = S_IDLE;
            end
            S_EXT_BRK: begin
               w_emit = 1'b1;
               w_ext  = 1'b1;
               w_rel  = 1'b1;
               w_next = S_IDLE;
            end
            S_PAUSE: begin
               w_skip_nxt = r_skip - 3'd1;
               if (r_skip == 3'd1) begin
                  w_emit = 1'b1;
                  w_code = C_PFX_E1;
                  w_next = S_IDLE;
               end
            end
            default: w_next = S_IDLE;
         endcase
      end else if (w_timeout) begin
         w_next = S_IDLE;
      end
   end

   always_ff @(posedge clock_25) begin
      if (reset || keyb_ready || (r_state == S_IDLE))
         r_tmo <= '0;
      else
         r_tmo <= r_tmo + 1'b1;
   end

   ps2_ascii_map u_ascii_map (
      .i_code  (w_code),
      .i_ext   (w_ext),
      .i_shift (mod_shift),
      .i_caps  (caps_lock),
      .o_ascii (w_ascii)
   );

   always_ff @(posedge clock_25) begin
      if (reset) begin
         r_ev_vld <= 1'b0;
         r_ev     <= '0;
      end else begin
         r_ev_vld <= w_emit;
         if (w_emit)
            r_ev <= '{code: w_code, ext: w_ext, rel: w_rel, ascii: w_ascii};
      end
   end

   // Modifiers track the decoded stream, independent of FIFO acceptance.
   always_ff @(posedge clock_25) begin
      if (reset) begin
         r_lshift <= 1'b0;
         r_rshift <= 1'b0;
         r_lctrl  <= 1'b0;
         r_rctrl  <= 1'b0;
         r_lalt   <= 1'b0;
         r_ralt   <= 1'b0;
         r_caps   <= 1'b0;
      end else if (w_emit) begin
         if (!w_ext && (w_code == C_KEY_LSHIFT)) r_lshift <= !w_rel;
         if (!w_ext && (w_code == C_KEY_RSHIFT)) r_rshift <= !w_rel;
         if (w_code == C_KEY_CTRL) begin
            if (w_ext) r_rctrl <= !w_rel;
            else       r_lctrl <= !w_rel;
         end
         if (w_code == C_KEY_ALT) begin
            if (w_ext) r_ralt <= !w_rel;
            else       r_lalt <= !w_rel;
         end
         if (!w_ext && !w_rel && (w_code == C_KEY_CAPS)) r_caps <= !r_caps;
      end
   end

   assign mod_shift = r_lshift | r_rshift;
   assign mod_ctrl  = r_lctrl  | r_rctrl;
   assign mod_alt   = r_lalt   | r_ralt;
   assign caps_lock = r_caps;

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[C_AW] != r_rptr[C_AW]) &&
                    (r_wptr[C_AW-1:0] == r_rptr[C_AW-1:0]);
   assign w_pop   = !w_empty && ev.ev_ready;
   assign w_push  = r_ev_vld && (!w_full || w_pop);

   always_ff @(posedge clock_25) begin
      if (w_push)
         r_mem[r_wptr[C_AW-1:0]] <= r_ev;
   end

   always_ff @(posedge clock_25) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (r_ev_vld && w_full && !w_pop) r_ovf <= 1'b1;
      end
   end

   assign overflow = r_ovf;

   // Head outputs are masked so an empty FIFO presents all-zero fields.
   assign w_head        = r_mem[r_rptr[C_AW-1:0]];
   assign ev.ev_valid   = !w_empty;
   assign ev.ev_code    = w_empty ? 8'h00 : w_head.code;
   assign ev.ev_ext     = w_empty ? 1'b0  : w_head.ext;
   assign ev.ev_release = w_empty ? 1'b0  : w_head.rel;
   assign ev.ev_ascii   = w_empty ? 8'h00 : w_head.ascii;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_scancode_decoder : directed scoreboard bench for the scan-code decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ps2_scancode_decoder;

   localparam int TB_TMO = 200;

   logic       clk;
   logic       reset;
   logic       keyb_ready;
   logic [7:0] keyb_data;
   logic       mod_shift, mod_ctrl, mod_alt, caps_lock, overflow;

   int errors = 0;
   int checks = 0;
   logic [17:0] q_exp [$];

   ps2_ev_if ev_if ();

   ps2_scancode_decoder #(
      .FIFO_DEPTH  (8),
      .TIMEOUT_CYC (TB_TMO)
   ) dut (
      .clock_25   (clk),
      .reset      (reset),
      .keyb_ready (keyb_ready),
      .keyb_data  (keyb_data),
      .ev         (ev_if),
      .mod_shift  (mod_shift),
      .mod_ctrl   (mod_ctrl),
      .mod_alt    (mod_alt),
      .caps_lock  (caps_lock),
      .overflow   (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Consumer side: every popped event is compared against the scoreboard.
   always @(negedge clk) begin
      if (!reset && ev_if.ev_valid && ev_if.ev_ready) begin
         if (q_exp.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_ev: observed=%0h expected=none",
                   {ev_if.ev_code, ev_if.ev_ext, ev_if.ev_release, ev_if.ev_ascii});
         end else begin
            check("ev", {14'd0, ev_if.ev_code, ev_if.ev_ext, ev_if.ev_release, ev_if.ev_ascii},
                  {14'd0, q_exp.pop_front()});
         end
      end
   end

   task automatic expect_ev(input logic [7:0] code, input logic ext, input logic rel,
                            input logic [7:0] ascii);
      q_exp.push_back({code, ext, rel, ascii});
   endtask

   task automatic send(input logic [7:0] b);
      keyb_ready = 1'b1;
      keyb_data  = b;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      keyb_ready = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain();
      keyb_ready = 1'b0;
      for (int i = 0; i < 200 && q_exp.size() != 0; i++) begin @(posedge clk); #1; end
      idle(3);
      check("drain_left", q_exp.size(), 0);
      check("drain_valid", ev_if.ev_valid, 1'b0);
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      keyb_ready = 1'b0;
      idle(2);
      reset = 1'b0;
      q_exp.delete();
   endtask

   initial begin
      reset           = 1'b1;
      keyb_ready      = 1'b0;
      keyb_data       = 8'h00;
      ev_if.ev_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", ev_if.ev_valid, 1'b0);
      check("rst_code", ev_if.ev_code, 8'h00);
      check("rst_ascii", ev_if.ev_ascii, 8'h00);
      check("rst_flags", {ev_if.ev_ext, ev_if.ev_release}, 2'b00);
      check("rst_mods", {mod_shift, mod_ctrl, mod_alt, caps_lock, overflow}, 5'b0);
      reset = 1'b0;
      idle(1);

      // single make, latency
      expect_ev(8'h1C, 1'b0, 1'b0, 8'h61);
      send(8'h1C);
      keyb_ready = 1'b0;
      check("lat_k1", ev_if.ev_valid, 1'b0);
      @(posedge clk); #1;
      check("lat_k2", ev_if.ev_valid, 1'b1);
      drain();

      // shift
      expect_ev(8'h12, 1'b0, 1'b0, 8'h00);
      expect_ev(8'h1C, 1'b0, 1'b0, 8'h41);
      expect_ev(8'h1C, 1'b0, 1'b1, 8'h41);
      expect_ev(8'h16, 1'b0, 1'b0, 8'h21);
      expect_ev(8'h12, 1'b0, 1'b1, 8'h00);
      send(8'h12);
      idle(1);
      check("shift_held", mod_shift, 1'b1);
      send(8'h1C); send(8'hF0); send(8'h1C); send(8'h16); send(8'hF0); send(8'h12);
      idle(1);
      check("shift_rel", mod_shift, 1'b0);
      drain();

      // caps lock
      expect_ev(8'h58, 1'b0, 1'b0, 8'h00);
      expect_ev(8'h58, 1'b0, 1'b1, 8'h00);
      expect_ev(8'h1C, 1'b0, 1'b0, 8'h41);
      expect_ev(8'h16, 1'b0, 1'b0, 8'h31);
      expect_ev(8'h12, 1'b0, 1'b0, 8'h00);
      expect_ev(8'h1C, 1'b0, 1'b0, 8'h61);
      expect_ev(8'h12, 1'b0, 1'b1, 8'h00);
      send(8'h58); send(8'hF0); send(8'h58);
      idle(1);
      check("caps_on", caps_lock, 1'b1);
      send(8'h1C); send(8'h16); send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
      drain();
      expect_ev(8'h58, 1'b0, 1'b0, 8'h00);
      expect_ev(8'h58, 1'b0, 1'b1, 8'h00);
      send(8'h58); send(8'hF0); send(8'h58);
      idle(1);
      check("caps_off", caps_lock, 1'b0);
      drain();

      // extended keys, specials, ignored bytes, right ctrl
      expect_ev(8'h75, 1'b1, 1'b0, 8'h00);
      expect_ev(8'h75, 1'b1, 1'b1, 8'h00);
      expect_ev(8'h29, 1'b0, 1'b0, 8'h20);
      expect_ev(8'h5A, 1'b1, 1'b0, 8'h0D);
      expect_ev(8'h4A, 1'b1, 1'b0, 8'h2F);
      expect_ev(8'h14, 1'b1, 1'b0, 8'h00);
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hAA); send(8'hFA); send(8'h29);
      send(8'hE0); send(8'h5A); send(8'hE0); send(8'h4A);
      send(8'hE0); send(8'h14);
      idle(1);
      check("rctrl_held", {mod_ctrl, mod_shift}, 2'b10);
      expect_ev(8'h14, 1'b1, 1'b1, 8'h00);
      send(8'hE0); send(8'hF0); send(8'h14);
      idle(1);
      check("rctrl_rel", mod_ctrl, 1'b0);
      drain();

      // pause: exactly one event
      expect_ev(8'hE1, 1'b0, 1'b0, 8'h00);
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      drain();
      check("pause_ctrl", mod_ctrl, 1'b0);

      // prefix timeout
      send(8'hE0);
      idle(TB_TMO + 20);
      expect_ev(8'h1C, 1'b0, 1'b0, 8'h61);
      send(8'h1C);
      drain();

      // reset during BRK, and reset beats a same-cycle strobe
      send(8'hF0);
      reset      = 1'b1;
      keyb_data  = 8'h1C;
      keyb_ready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      idle(4);
      check("rst_mid_valid", ev_if.ev_valid, 1'b0);
      expect_ev(8'h1C, 1'b0, 1'b0, 8'h61);
      send(8'h1C);
      drain();

      // write to a full FIFO with a same-cycle pop is accepted
      ev_if.ev_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         expect_ev(8'h1C, 1'b0, 1'b0, 8'h61);
         send(8'h1C);
      end
      idle(3);
      expect_ev(8'h32, 1'b0, 1'b0, 8'h62);
      send(8'h32);
      keyb_ready     = 1'b0;
      ev_if.ev_ready = 1'b1;
      @(posedge clk); #1;
      ev_if.ev_ready = 1'b0;
      idle(2);
      check("full_pop_ovf", overflow, 1'b0);
      ev_if.ev_ready = 1'b1;
      drain();

      // nine makes into eight slots
      ev_if.ev_ready = 1'b0;
      expect_ev(8'h1C, 1'b0, 1'b0, 8'h61);
      expect_ev(8'h32, 1'b0, 1'b0, 8'h62);
      expect_ev(8'h21, 1'b0, 1'b0, 8'h63);
      expect_ev(8'h23, 1'b0, 1'b0, 8'h64);
      expect_ev(8'h24, 1'b0, 1'b0, 8'h65);
      expect_ev(8'h2B, 1'b0, 1'b0, 8'h66);
      expect_ev(8'h34, 1'b0, 1'b0, 8'h67);
      expect_ev(8'h33, 1'b0, 1'b0, 8'h68);
      send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
      send(8'h2B); send(8'h34); send(8'h33); send(8'h43);
      idle(4);
      check("ovf_set", overflow, 1'b1);
      check("ovf_valid", ev_if.ev_valid, 1'b1);
      ev_if.ev_ready = 1'b1;
      drain();
      check("ovf_sticky", overflow, 1'b1);

      do_reset();
      check("ovf_cleared", overflow, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Sits directly downstream of the PS/2 byte receiver (keyboard) in clock_25. Consumes raw Set-2 scan-code bytes and resolves E0/F0/E1 prefix sequences into single key events. Each event carries a make/break flag, an extended flag, modifier state and an ASCII translation. Events are buffered in a small FIFO for a consumer, such as the HEX display or a CPU port, to pop with a ready/valid handshake.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2.
TIMEOUT_CYC, 250000, clock_25 cycles (10 ms) a prefix may wait for its next byte before the FSM abandons the sequence.

Ports:
clock_25  input  1  system clock, 25 MHz.
reset  input  1  synchronous, active-high reset.
keyb_ready  input  1  one-cycle strobe; keyb_data is valid in this cycle.
keyb_data  input  8  received scan-code byte.
ev_valid  output  1  FIFO head holds an event.
ev_ready  input  1  consumer pops the head when ev_valid && ev_ready.
ev_code  output  8  base scan code; 8'hE1 for Pause.
ev_ext  output  1  event had an E0 prefix.
ev_release  output  1  1 = break, 0 = make.
ev_ascii  output  8  ASCII value; 8'h00 if the key has no mapping.
mod_shift  output  1  live state: left (12) OR right (59) shift held.
mod_ctrl  output  1  live state: left (14) OR right (E0 14) ctrl held.
mod_alt  output  1  live state: left (11) OR right (E0 11) alt held.
caps_lock  output  1  toggles on each make of 58; a break has no effect.
overflow  output  1  sticky; set when an event is dropped because the FIFO is full.

Behaviour:
- Interface: one clock (clock_25); reset is synchronous and active-high.
- Reset values:
  - FSM returns to IDLE; FIFO is emptied.
  - ev_valid=0; all modifiers, caps_lock and overflow are 0.
  - ev_code/ev_ascii=8'h00; ev_ext/ev_release=0.
- Reset mid-sequence discards any partial prefix.
- Reset wins over a keyb_ready in the same cycle.
- FSM acts only on cycles where keyb_ready=1. States:
  - IDLE:
    - E0 -> EXT; F0 -> BRK; E1 -> PAUSE (skip count = 7).
    - AA, FA, FE, EE, 00, FF -> ignored, stay IDLE.
    - Any other byte -> emit make(code, ext=0).
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte -> emit make(code, ext=1), go IDLE.
  - BRK: any byte -> emit break(code, ext=0), go IDLE.
  - EXT_BRK: any byte -> emit break(code, ext=1), go IDLE.
  - PAUSE: decrement the skip count per byte. When it reaches 0, emit make(E1, ext=0) and go IDLE. Pause never produces a break event.
- Timeout: a counter runs while not in IDLE and is cleared on each keyb_ready. At TIMEOUT_CYC the FSM goes to IDLE with no event emitted.
- Emit pipeline:
  - The byte strobed in cycle k produces an event register loaded at the end of cycle k.
  - That event is written to the FIFO at the end of cycle k+1.
  - ev_valid rises in cycle k+2 if the FIFO was empty (2-cycle latency).
- Modifiers update at the same edge the event register loads. They update even if the event is later dropped.
- ASCII is computed at event-register load from the pre-update modifier state. Rules:
  - Letters: uppercase iff mod_shift XOR caps_lock.
  - Digits and punctuation: shifted variant iff mod_shift.
  - Space 29 -> 20; Enter 5A and E0 5A -> 0D; Backspace 66 -> 08; Esc 76 -> 1B; Tab 0D -> 09; E0 4A -> 2F.
  - All other extended codes -> 00.
  - mod_ctrl does not alter ASCII.
  - Break events carry the same ASCII as the matching make.
- FIFO:
  - First-word-fall-through; outputs come from the head entry.
  - Pop occurs when ev_valid && ev_ready.
  - Write when full without a same-cycle pop: event dropped, overflow set to 1.
  - Write when full with a same-cycle pop: accepted, no overflow.
  - Simultaneous write and pop on an empty FIFO is impossible, since ev_valid=0.
  - Pointers wrap modulo FIFO_DEPTH; an extra count bit distinguishes full from empty.
- Back-to-back keyb_ready strobes on consecutive cycles must be handled without loss, FIFO space permitting.

Decomposition:
- Package ps2_pkg:
  - Prefix constants (E0, F0, E1) and the ignored-byte list.
  - Modifier codes (12, 59, 14, 11, 58).
  - FSM state enum.
  - Event struct {code, ext, release, ascii}.
- Sub-module ps2_ascii_map: purely combinational Set-2-to-ASCII lookup. Inputs: code, ext, shift, caps. Output: ascii.
- FIFO is inline; it is small.

Test Plan:
- Reset then bytes 1C -> one event {code 1C, ext 0, release 0, ascii 61}; ev_valid rises 2 cycles after the strobe.
- Bytes 12, 1C, F0 1C, F0 12 -> four events: make 12, make 1C ascii 41, break 1C ascii 41, break 12. mod_shift reads 1 between the make and break of 12, 0 after.
- Bytes 58, F0 58, 1C, then 12, 1C -> caps_lock=1; the two 1C makes give ascii 41 then 61.
- Bytes E0 75, E0 F0 75 -> {75, ext 1, make, ascii 00} then {75, ext 1, break}. Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event, code E1.
- E0 then idle 250000 cycles then 1C -> single event {1C, ext 0}. Assert reset during BRK, then send 1C -> a make event, not a break.
- With ev_ready=0, send 9 make codes -> 8 events held, overflow=1. Then hold ev_ready=1 -> events pop in the order sent.
